// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue and send sequencer feeding a UART transmitter.
// The processor pushes bytes at any rate. The sequencer pops one byte at a time
// and hands it to the transmitter with a single-cycle tx_dv pulse. It then waits
// for tx_done before it considers the next byte.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              busy,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    input  logic              tx_active,
    input  logic              tx_done
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    state_t            state;
    state_t            state_next;
    logic              pop_req;
    logic              push_ok;

    // The status flags come only from registers, so no input reaches an output combinationally.
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign busy  = (state != IDLE) || !empty;

    // A write is dropped when the queue is full, even if a pop happens in the same cycle.
    assign push_ok = wr_en && !full;

    // The FSM state register returns to IDLE on reset, whatever the transmitter is doing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and pop decision. IDLE holds off while the transmitter is active or in its done tail.
    always_comb begin
        state_next = state;
        pop_req    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_active && !tx_done) begin
                    pop_req    = 1'b1;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered handoff to the transmitter. tx_byte holds its value until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            tx_dv <= pop_req;
            if (pop_req) begin
                tx_byte <= mem[rd_ptr];
            end
        end
    end

    // Storage array. Contents need no reset because the pointers and the count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag. When a push and a pop coincide, the count does not change.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_req) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop_req) begin
                count <= count + CNT_ONE;
            end else if (pop_req && !push_ok) begin
                count <= count - CNT_ONE;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Internal consistency properties. Synthesis ignores them.
    a_count_range : assert property (@(posedge clk) disable iff (rst) count <= DEPTH_CNT);
    a_count_ptrs  : assert property (@(posedge clk) disable iff (rst)
                                     count[ADDR_W-1:0] == ADDR_W'(wr_ptr - rd_ptr));
    a_dv_single   : assert property (@(posedge clk) disable iff (rst) tx_dv |=> !tx_dv);
    a_ovf_sticky  : assert property (@(posedge clk) disable iff (rst) overflow |=> overflow);

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and send sequencer that sits directly upstream of the UART transmitter. The processor side pushes bytes at any rate into an internal FIFO. The block pops them one at a time and hands each to the transmitter with a single-cycle `tx_dv` pulse, then waits for `tx_done` before issuing the next byte. It decouples processor writes from serial line timing and guarantees the transmitter is never given a byte while busy.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2–256.
- `ADDR_W`, 4: log2(DEPTH).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  push `wr_data` this cycle.
- `wr_data`  in  8  byte to queue.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  ADDR_W+1  bytes currently queued, excluding the byte in flight.
- `overflow`  out  1  sticky; set when `wr_en` arrives while full.
- `busy`  out  1  high when state ≠ IDLE or !empty.
- `tx_dv`  out  1  one-cycle start pulse to the transmitter.
- `tx_byte`  out  8  byte to the transmitter; registered, held stable from the `tx_dv` cycle until the next pop.
- `tx_active`  in  1  transmitter busy flag.
- `tx_done`  in  1  transmitter completion flag; high 2 cycles at frame end.

## Operation
- FIFO: circular buffer `mem[DEPTH]`, `wr_ptr`/`rd_ptr` of ADDR_W bits with natural wrap, plus a separate `count` register.
- Push: when `wr_en && !full`, write `mem[wr_ptr]`, then `wr_ptr++` and `count++`. When `wr_en && full`, drop the byte, set `overflow`, and leave pointers and count unchanged.
- Pop: happens only in the IDLE→WAIT_DONE transition. `tx_byte <= mem[rd_ptr]`, `rd_ptr++`, `count--`.
- Simultaneous push and pop: the net `count` change is 0; both pointers advance. A push while full is dropped even if a pop occurs in the same cycle.
- FSM has two states, encoded 1 bit:
  - IDLE: if `!empty && !tx_active && !tx_done`, pop, set `tx_dv <= 1`, go to WAIT_DONE. Otherwise stay, with `tx_dv <= 0`.
  - WAIT_DONE: `tx_dv <= 0`. On `tx_done == 1`, go to IDLE. Otherwise stay.
- The IDLE guard on `!tx_done` absorbs the transmitter's 2-cycle done/cleanup tail. A new `tx_dv` is issued only once the transmitter is back in its idle state.
- Reset mid-operation: FIFO contents are discarded and the FSM returns to IDLE. The transmitter has no reset and may finish its current frame; the IDLE guard holds off any new `tx_dv` until its `tx_active` and `tx_done` are both low.

## Timing
- Reset values: `tx_dv` = 0, `tx_byte` = 0x00, `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `busy` = 0, state = IDLE, pointers = 0.
- `full`, `empty` and `busy` are combinational from registers; there are no combinational paths from inputs to outputs.
- Latency with the transmitter idle: `wr_en` is sampled at edge N, so `count` = 1 after N. `tx_dv` is high from N+1 to N+2, with `tx_byte` valid in the same cycle.
- `tx_dv` is never high for two consecutive cycles. It is never high while `tx_active` or `tx_done` is high.
- Back-to-back bytes: after `tx_done` first goes high at edge M, the next `tx_dv` is high at the earliest from M+3, because `done` stays high during cleanup and clears one cycle into idle.
- `count` excludes the in-flight byte. A FIFO of DEPTH entries plus one byte in the transmitter can be outstanding.

## Test plan
Bench pairs the block with the transmitter at `CLKS_PER_BIT` = 4 and decodes the serial line.
1. Reset, then a single write of 0x55 → `tx_dv` pulses exactly 1 cycle, 1 cycle after `count` = 1. The line shows start bit, then 1,0,1,0,1,0,1,0 LSB-first, then stop. `busy` falls after `tx_done`.
2. Burst of 5 writes (0x01–0x05) on consecutive cycles → `count` peaks at 4. The line carries 5 frames in order. Exactly 5 `tx_dv` pulses, each ≥3 cycles after the preceding `tx_done` rise.
3. Write 17 bytes while the transmitter is busy, with `DEPTH` = 16 → the first byte goes in flight, the next 16 fill the FIFO (`full` = 1), and no overflow occurs. An 18th write sets `overflow`, and the dropped byte never appears on the line.
4. With `full` = 1, assert `wr_en` in the same cycle as a pop → the write is dropped, `overflow` = 1, and `count` = 15.
5. Fill with 0xA0–0xAF and drain, then refill with 0xB0–0xBF → correct order across pointer wrap-around. `empty` = 1 at the end.
6. Assert `rst` mid-frame with 3 bytes queued → `count` = 0 and `tx_dv` = 0 immediately. No `tx_dv` until the transmitter's `tx_done` clears. A subsequent write of 0x3C transmits correctly.
